// File: rtl/wave_gen_multi.sv
// wave_gen_multi: saw/reverse-saw/triangle/square generator with prescaler; WAVEGEN_PHASE_OFS_EN adds a phase_ofs input
module wave_gen_multi #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] duty,
  input  logic [DIV_W-1:0] div,
`ifdef WAVEGEN_PHASE_OFS_EN
  input  logic [WIDTH-1:0] phase_ofs,
`endif
  output logic [WIDTH-1:0] wave_out,
  output logic             period_tick,
  output logic             dir_down
);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  logic [1:0] mode_r;
  logic [WIDTH-1:0] step_r, duty_r, phase, tri_v, phase_nx, tri_nx, ph_o, sample;
  logic [DIV_W-1:0] div_r, presc;
  logic tick, carry, dir_nx, tri_zero, mode_chg, pend, wrap_d;
`ifdef WAVEGEN_PHASE_OFS_EN
  logic [WIDTH-1:0] ofs_r;
  always_ff @(posedge clk or posedge reset)
    if (reset) ofs_r <= '0;
    else if (load) ofs_r <= phase_ofs;
`endif
  always_comb begin
    tick = en && presc == div_r;
    mode_chg = load && mode != mode_r;
    {carry, phase_nx} = {1'b0, phase} + {1'b0, step_r};
    tri_nx = dir_down ? (tri_v < step_r ? '0 : tri_v - step_r)
                      : (tri_v > MAX - step_r ? MAX : tri_v + step_r);
    dir_nx = dir_down ? !(tri_v < step_r) : (tri_v > MAX - step_r);
    tri_zero = dir_down && tri_v != '0 && tri_v <= step_r;
`ifdef WAVEGEN_PHASE_OFS_EN
    ph_o = phase + ofs_r;
`else
    ph_o = phase;
`endif
    sample = mode_r == 2'd0 ? ph_o :
             mode_r == 2'd1 ? ~ph_o :
             mode_r == 2'd2 ? tri_v :
             (ph_o < duty_r ? MAX : '0);
  end
  // pend/wrap_d carry a tick's result to the following cycle's output update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r      <= '0;
      step_r      <= WIDTH'(1);
      duty_r      <= MAX ^ (MAX >> 1);
      div_r       <= '0;
      phase       <= '0;
      tri_v       <= '0;
      dir_down    <= 1'b0;
      presc       <= '0;
      pend        <= 1'b0;
      wrap_d      <= 1'b0;
      wave_out    <= '0;
      period_tick <= 1'b0;
    end else begin
      if (load) begin
        mode_r <= mode;
        step_r <= step;
        duty_r <= duty;
        div_r  <= div;
      end
      if (mode_chg) begin
        phase    <= '0;
        tri_v    <= '0;
        dir_down <= 1'b0;
        presc    <= '0;
        pend     <= 1'b0;
        wrap_d   <= 1'b0;
      end else if (en) begin
        presc  <= tick ? '0 : presc + 1'b1;
        pend   <= tick;
        wrap_d <= mode_r == 2'd2 ? tri_zero : carry;
        if (tick) phase <= phase_nx;
        if (tick && mode_r == 2'd2) begin
          tri_v    <= tri_nx;
          dir_down <= dir_nx;
        end
      end
      if (en && pend) wave_out <= sample;
      period_tick <= en && pend && wrap_d;
    end
  end
endmodule

// File: tb/tb_wave_gen_multi.sv
// tb_wave_gen_multi: directed checks of wave_gen_multi in its default build
module tb_wave_gen_multi;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] step = 8'd1, duty = 8'd128, wave_out;
  logic [15:0] div = '0;
  logic period_tick, dir_down;
  int checks = 0, failures = 0;

  wave_gen_multi #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .mode(mode), .step(step),
    .duty(duty), .div(div), .wave_out(wave_out), .period_tick(period_tick), .dir_down(dir_down)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] s, input logic [7:0] d, input logic [15:0] dv);
    en = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mode = m; step = s; duty = d; div = dv; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    checks++;
    if (wave_out !== 8'd0 || period_tick !== 1'b0 || dir_down !== 1'b0) begin
      failures++;
      $display("FAIL reset: wave=%0d tick=%b dir=%b expected 0/0/0", wave_out, period_tick, dir_down);
    end
    reset = 1'b0;
  endtask

  task automatic test_saw();
    cfg(2'd0, 8'd1, 8'd128, 16'd0);
    en = 1'b1;
    cyc();
    for (int i = 1; i <= 256; i++) begin
      cyc();
      checks++;
      if (wave_out !== 8'(i) || period_tick !== (i == 256)) begin
        failures++;
        $display("FAIL saw[%0d]: wave=%0d tick=%b expected %0d/%b", i, wave_out, period_tick, 8'(i), i == 256);
      end
    end
  endtask

  task automatic test_rev_saw();
    cfg(2'd1, 8'd1, 8'd128, 16'd0);
    en = 1'b1;
    cyc();
    for (int i = 1; i <= 256; i++) begin
      cyc();
      checks++;
      if (wave_out !== 8'(255 - i) || period_tick !== (i == 256)) begin
        failures++;
        $display("FAIL rsaw[%0d]: wave=%0d tick=%b expected %0d/%b", i, wave_out, period_tick, 8'(255 - i), i == 256);
      end
    end
  endtask

  task automatic test_triangle();
    int exp_w[7] = '{100, 200, 255, 155, 55, 0, 100};
    cfg(2'd2, 8'd100, 8'd128, 16'd0);
    en = 1'b1;
    cyc();
    for (int k = 0; k < 7; k++) begin
      cyc();
      checks++;
      if (wave_out !== 8'(exp_w[k]) || period_tick !== (k == 5)) begin
        failures++;
        $display("FAIL tri[%0d]: wave=%0d tick=%b expected %0d/%b", k, wave_out, period_tick, exp_w[k], k == 5);
      end
      if (k == 2 || k == 5) begin
        checks++;
        if (dir_down !== (k == 2)) begin
          failures++;
          $display("FAIL tri_dir[%0d]: dir=%b expected %b", k, dir_down, k == 2);
        end
      end
    end
  endtask

  task automatic test_square();
    logic [7:0] e;
    cfg(2'd3, 8'd1, 8'd64, 16'd0);
    en = 1'b1;
    cyc();
    for (int i = 1; i <= 256; i++) begin
      cyc();
      e = (i % 256) < 64 ? 8'd255 : 8'd0;
      checks++;
      if (wave_out !== e || period_tick !== (i == 256)) begin
        failures++;
        $display("FAIL square[%0d]: wave=%0d tick=%b expected %0d/%b", i, wave_out, period_tick, e, i == 256);
      end
    end
    cfg(2'd3, 8'd1, 8'd0, 16'd0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (wave_out !== 8'd0) begin
        failures++;
        $display("FAIL square_duty0[%0d]: wave=%0d expected 0", i, wave_out);
      end
    end
  endtask

  task automatic test_step_zero();
    cfg(2'd0, 8'd0, 8'd128, 16'd0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (wave_out !== 8'd0 || period_tick !== 1'b0) begin
        failures++;
        $display("FAIL step0[%0d]: wave=%0d tick=%b expected 0/0", i, wave_out, period_tick);
      end
    end
  endtask

  task automatic test_div_enable();
    cfg(2'd0, 8'd1, 8'd128, 16'd3);
    en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      checks++;
      if (wave_out !== 8'((n - 1) / 4)) begin
        failures++;
        $display("FAIL div3[%0d]: wave=%0d expected %0d", n, wave_out, (n - 1) / 4);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (wave_out !== 8'd9 || period_tick !== 1'b0) begin
        failures++;
        $display("FAIL en_low[%0d]: wave=%0d tick=%b expected 9/0", i, wave_out, period_tick);
      end
    end
    en = 1'b1;
    for (int n = 41; n <= 48; n++) begin
      cyc();
      checks++;
      if (wave_out !== 8'((n - 1) / 4)) begin
        failures++;
        $display("FAIL resume[%0d]: wave=%0d expected %0d", n, wave_out, (n - 1) / 4);
      end
    end
  endtask

  task automatic test_mode_change();
    int exp_w[4] = '{51, 51, 254, 253};
    cfg(2'd0, 8'd1, 8'd128, 16'd0);
    en = 1'b1;
    repeat (51) cyc();
    checks++;
    if (wave_out !== 8'd50) begin
      failures++;
      $display("FAIL mchg_pre: wave=%0d expected 50", wave_out);
    end
    mode = 2'd1;
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      load = 1'b0;
      checks++;
      if (wave_out !== 8'(exp_w[k])) begin
        failures++;
        $display("FAIL mchg[%0d]: wave=%0d expected %0d", k, wave_out, exp_w[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_w[4] = '{11, 12, 22, 32};
    cfg(2'd0, 8'd1, 8'd128, 16'd0);
    en = 1'b1;
    repeat (11) cyc();
    step = 8'd10;
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      load = 1'b0;
      checks++;
      if (wave_out !== 8'(exp_w[k])) begin
        failures++;
        $display("FAIL load_tick[%0d]: wave=%0d expected %0d", k, wave_out, exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg(2'd2, 8'd100, 8'd128, 16'd0);
    en = 1'b1;
    repeat (5) cyc();
    checks++;
    if (wave_out !== 8'd155 || dir_down !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre: wave=%0d dir=%b expected 155/1", wave_out, dir_down);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (wave_out !== 8'd0 || dir_down !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async: wave=%0d dir=%b expected 0/0", wave_out, dir_down);
    end
    #1;
    reset = 1'b0;
    repeat (3) cyc();
    checks++;
    if (wave_out !== 8'd2 || period_tick !== 1'b0) begin
      failures++;
      $display("FAIL rmid_defaults: wave=%0d tick=%b expected 2/0", wave_out, period_tick);
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_rev_saw();
    test_triangle();
    test_square();
    test_step_zero();
    test_div_enable();
    test_mode_change();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
